// File: rtl/tm1638_key_event_queue.sv
// Debounces the 8 TM1638 keys and queues press/release/auto-repeat events in a show-ahead FIFO.
// Latency: KEYS_DEB_o one cycle after the ms tick; head event visible 2..9 cycles after the tick.
// Backpressure: none upstream; a push into a full FIFO without a pop is dropped and sets OVF_o.
module tm1638_key_event_queue #(
    parameter int C_FCK        = 48_000_000,
    parameter int C_DEB_MS     = 20,
    parameter int C_RPT_DLY_MS = 500,
    parameter int C_RPT_MS     = 100,
    parameter int C_FIFO_DEPTH = 8
) (
    input  logic                            CK_i,
    input  logic                            XARST_i,
    input  logic [7:0]                      KEYS_i,
    input  logic                            CLR_i,
    input  logic                            POP_i,
    output logic                            EV_VALID_o,
    output logic [2:0]                      EV_KEY_o,
    output logic [1:0]                      EV_TYPE_o,
    output logic [7:0]                      KEYS_DEB_o,
    output logic [$clog2(C_FIFO_DEPTH):0]   COUNT_o,
    output logic                            FULL_o,
    output logic                            OVF_o
);
    localparam int TICK_N = C_FCK / 1000;
    localparam int PW     = $clog2(TICK_N);
    localparam int AW     = $clog2(C_FIFO_DEPTH);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_N - 1);
    localparam logic [7:0]    DEB_LAST  = 8'(C_DEB_MS - 1);
    localparam logic [11:0]   DLY_LAST  = 12'(C_RPT_DLY_MS - 1);
    localparam logic [11:0]   RPT_LAST  = 12'(C_RPT_MS - 1);
    localparam logic [AW:0]   DEPTH     = C_FIFO_DEPTH[AW:0];

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pre_ctr;
    logic          tick;
    logic [7:0]    key_meta, key_sync;
    logic [7:0]    deb, deb_nxt;
    logic [7:0]    deb_ctr     [8];
    logic [7:0]    deb_ctr_nxt [8];
    logic [11:0]   rpt_ctr     [8];
    logic [11:0]   rpt_ctr_nxt [8];
    logic [7:0]    rpt_ph, rpt_ph_nxt;
    logic [7:0]    post;
    logic [1:0]    post_type   [8];
    logic [7:0]    pend;
    logic [1:0]    pend_type   [8];
    logic [2:0]    sel;
    logic          push_req;
    logic [7:0]    grant;
    logic [4:0]    mem [C_FIFO_DEPTH];
    logic [4:0]    head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          ovf;
    logic          do_push, do_pop;

    assign tick = (pre_ctr == TICK_LAST);

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            pre_ctr  <= '0;
            key_meta <= '0;
            key_sync <= '0;
        end else begin
            pre_ctr  <= tick ? '0 : pre_ctr + 1'b1;
            key_meta <= KEYS_i;
            key_sync <= key_meta;
        end
    end

    // rpt_ph: 0 = waiting for the initial delay, 1 = periodic repeat
    always_comb begin
        deb_nxt    = deb;
        rpt_ph_nxt = rpt_ph;
        post       = '0;
        for (int k = 0; k < 8; k++) begin
            deb_ctr_nxt[k] = deb_ctr[k];
            rpt_ctr_nxt[k] = rpt_ctr[k];
            post_type[k]   = 2'b00;
            if (tick) begin
                if (key_sync[k] == deb[k]) begin
                    deb_ctr_nxt[k] = '0;
                end else if (deb_ctr[k] == DEB_LAST) begin
                    deb_nxt[k]     = key_sync[k];
                    deb_ctr_nxt[k] = '0;
                    post[k]        = 1'b1;
                    post_type[k]   = key_sync[k] ? 2'b01 : 2'b10;
                end else begin
                    deb_ctr_nxt[k] = deb_ctr[k] + 8'd1;
                end
                if (post[k] || !deb[k]) begin
                    rpt_ctr_nxt[k] = '0;
                    rpt_ph_nxt[k]  = 1'b0;
                end else if (rpt_ctr[k] == (rpt_ph[k] ? RPT_LAST : DLY_LAST)) begin
                    rpt_ctr_nxt[k] = '0;
                    rpt_ph_nxt[k]  = 1'b1;
                    post[k]        = 1'b1;
                    post_type[k]   = 2'b11;
                end else begin
                    rpt_ctr_nxt[k] = rpt_ctr[k] + 12'd1;
                end
            end
            if (CLR_i) begin
                rpt_ctr_nxt[k] = '0;
                rpt_ph_nxt[k]  = 1'b0;
                post[k]        = 1'b0;
            end
        end
    end

    always_comb begin
        sel = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (pend[k]) sel = 3'(k);
        end
    end

    assign push_req = (state == S_SCAN) && (pend != 8'h00);
    assign grant    = push_req ? (8'h01 << sel) : 8'h00;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pend != 8'h00) state_nxt = S_SCAN;
            S_SCAN:  if (pend == 8'h00) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (CLR_i) state_nxt = S_IDLE;
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state  <= S_IDLE;
            deb    <= '0;
            rpt_ph <= '0;
            pend   <= '0;
            for (int k = 0; k < 8; k++) begin
                deb_ctr[k]   <= '0;
                rpt_ctr[k]   <= '0;
                pend_type[k] <= '0;
            end
        end else begin
            state  <= state_nxt;
            deb    <= deb_nxt;
            rpt_ph <= rpt_ph_nxt;
            pend   <= CLR_i ? 8'h00 : ((pend & ~grant) | post);
            for (int k = 0; k < 8; k++) begin
                deb_ctr[k] <= deb_ctr_nxt[k];
                rpt_ctr[k] <= rpt_ctr_nxt[k];
                if (post[k]) pend_type[k] <= post_type[k];
            end
        end
    end

    // A simultaneous pop frees the slot, so a push into a full FIFO is kept
    assign do_pop  = POP_i && (count != '0) && !CLR_i;
    assign do_push = push_req && !CLR_i && ((count != DEPTH) || do_pop);

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            for (int i = 0; i < C_FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (CLR_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {sel, pend_type[sel]};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_req && !do_push) ovf <= 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    assign head       = mem[rd_ptr];
    assign EV_VALID_o = (count != '0);
    assign EV_KEY_o   = EV_VALID_o ? head[4:2] : 3'd0;
    assign EV_TYPE_o  = EV_VALID_o ? head[1:0] : 2'd0;
    assign KEYS_DEB_o = deb;
    assign COUNT_o    = count;
    assign FULL_o     = (count == DEPTH);
    assign OVF_o      = ovf;

endmodule

// File: tb/tb_tm1638_key_event_queue.sv
// Bench for tm1638_key_event_queue: tick-level reference model of debounce/repeat plus a queue-based FIFO model.
module tb_tm1638_key_event_queue;
    localparam int DEPTH = 4;
    localparam int C_DEB = 3;
    localparam int C_DLY = 10;
    localparam int C_RPT = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CK_i;
    logic          XARST_i;
    logic [7:0]    KEYS_i;
    logic          CLR_i;
    logic          POP_i;
    logic          EV_VALID_o;
    logic [2:0]    EV_KEY_o;
    logic [1:0]    EV_TYPE_o;
    logic [7:0]    KEYS_DEB_o;
    logic [CW-1:0] COUNT_o;
    logic          FULL_o;
    logic          OVF_o;

    tm1638_key_event_queue #(
        .C_FCK(16_000), .C_DEB_MS(C_DEB), .C_RPT_DLY_MS(C_DLY),
        .C_RPT_MS(C_RPT), .C_FIFO_DEPTH(DEPTH)
    ) dut (
        .CK_i(CK_i), .XARST_i(XARST_i), .KEYS_i(KEYS_i), .CLR_i(CLR_i), .POP_i(POP_i),
        .EV_VALID_o(EV_VALID_o), .EV_KEY_o(EV_KEY_o), .EV_TYPE_o(EV_TYPE_o),
        .KEYS_DEB_o(KEYS_DEB_o), .COUNT_o(COUNT_o), .FULL_o(FULL_o), .OVF_o(OVF_o)
    );

    initial begin
        CK_i = 1'b0;
        forever #5 CK_i = ~CK_i;
    end

    int         n_chk;
    int         n_err;
    logic [7:0] m_deb;
    int         m_cnt  [8];
    int         m_held [8];
    logic [4:0] m_q [$];
    logic       m_ovf;
    logic [4:0] got_q [$];
    int         cnt_trace [11];
    int         key_trace [11];

    task automatic model_reset();
        m_deb = 8'h00;
        m_ovf = 1'b0;
        m_q.delete();
        for (int k = 0; k < 8; k++) begin
            m_cnt[k]  = 0;
            m_held[k] = 0;
        end
    endtask

    task automatic model_push(input int k, input logic [1:0] t);
        if (m_q.size() < DEPTH) m_q.push_back({3'(k), t});
        else m_ovf = 1'b1;
    endtask

    // Events of one tick enter the queue in ascending key order
    task automatic model_tick(input logic [7:0] raw);
        bit acc;
        for (int k = 0; k < 8; k++) begin
            acc = 1'b0;
            if (raw[k] != m_deb[k]) begin
                m_cnt[k]++;
                if (m_cnt[k] == C_DEB) begin
                    m_deb[k]  = raw[k];
                    m_cnt[k]  = 0;
                    m_held[k] = 0;
                    acc       = 1'b1;
                    model_push(k, raw[k] ? 2'b01 : 2'b10);
                end
            end else begin
                m_cnt[k] = 0;
            end
            if (!acc) begin
                if (m_deb[k]) begin
                    m_held[k]++;
                    if (m_held[k] >= C_DLY && (m_held[k] - C_DLY) % C_RPT == 0) model_push(k, 2'b11);
                end else begin
                    m_held[k] = 0;
                end
            end
        end
    endtask

    // One 16-cycle tick period: starts and ends 10 cycles after a tick edge.
    task automatic tick_step(input logic [7:0] keys, input int npop, input int pop_cyc, input bit clr);
        KEYS_i = keys;
        for (int i = 0; i < npop; i++) begin
            if (m_q.size() > 0) begin
                n_chk++;
                if ({EV_VALID_o, EV_KEY_o, EV_TYPE_o} !== {1'b1, m_q[0]}) begin
                    n_err++;
                    $display("FAIL pop_head got v=%0b key=%0d type=%0d exp key=%0d type=%0d",
                             EV_VALID_o, EV_KEY_o, EV_TYPE_o, m_q[0][4:2], m_q[0][1:0]);
                end
                got_q.push_back({EV_KEY_o, EV_TYPE_o});
                void'(m_q.pop_front());
            end
            POP_i = 1'b1;
            @(posedge CK_i);
            @(negedge CK_i);
            POP_i = 1'b0;
        end
        if (clr) begin
            CLR_i = 1'b1;
            @(posedge CK_i);
            @(negedge CK_i);
            CLR_i = 1'b0;
            m_q.delete();
            m_ovf = 1'b0;
            for (int k = 0; k < 8; k++) m_held[k] = 0;
        end
        repeat (6 - npop - int'(clr)) @(posedge CK_i);
        @(negedge CK_i);
        for (int c = 1; c <= 10; c++) begin
            if (c == pop_cyc && m_q.size() > 0) begin
                n_chk++;
                if ({EV_VALID_o, EV_KEY_o, EV_TYPE_o} !== {1'b1, m_q[0]}) begin
                    n_err++;
                    $display("FAIL tick_pop_head got key=%0d type=%0d exp key=%0d type=%0d",
                             EV_KEY_o, EV_TYPE_o, m_q[0][4:2], m_q[0][1:0]);
                end
                got_q.push_back({EV_KEY_o, EV_TYPE_o});
                void'(m_q.pop_front());
            end
            POP_i = (c == pop_cyc);
            @(posedge CK_i);
            @(negedge CK_i);
            POP_i = 1'b0;
            cnt_trace[c] = int'(COUNT_o);
            key_trace[c] = int'(EV_KEY_o);
        end
        model_tick(keys);
        n_chk++;
        if (KEYS_DEB_o !== m_deb) begin
            n_err++; $display("FAIL keys_deb got %h exp %h", KEYS_DEB_o, m_deb);
        end
        n_chk++;
        if (int'(COUNT_o) != m_q.size()) begin
            n_err++; $display("FAIL count got %0d exp %0d", COUNT_o, m_q.size());
        end
        n_chk++;
        if (FULL_o !== (m_q.size() == DEPTH)) begin
            n_err++; $display("FAIL full got %0b exp %0b", FULL_o, m_q.size() == DEPTH);
        end
        n_chk++;
        if (OVF_o !== m_ovf) begin
            n_err++; $display("FAIL ovf got %0b exp %0b", OVF_o, m_ovf);
        end
        n_chk++;
        if (EV_VALID_o !== (m_q.size() > 0)) begin
            n_err++; $display("FAIL ev_valid got %0b exp %0b", EV_VALID_o, m_q.size() > 0);
        end
        if (m_q.size() > 0) begin
            n_chk++;
            if ({EV_KEY_o, EV_TYPE_o} !== m_q[0]) begin
                n_err++;
                $display("FAIL head got key=%0d type=%0d exp key=%0d type=%0d",
                         EV_KEY_o, EV_TYPE_o, m_q[0][4:2], m_q[0][1:0]);
            end
        end
    endtask

    task automatic do_reset();
        XARST_i = 1'b0;
        #1;
        n_chk++;
        if ({EV_VALID_o, EV_KEY_o, EV_TYPE_o, KEYS_DEB_o, COUNT_o, FULL_o, OVF_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got v=%0b key=%0d type=%0d deb=%h cnt=%0d full=%0b ovf=%0b exp all 0",
                     EV_VALID_o, EV_KEY_o, EV_TYPE_o, KEYS_DEB_o, COUNT_o, FULL_o, OVF_o);
        end
        repeat (3) @(posedge CK_i);
        @(negedge CK_i);
        XARST_i = 1'b1;
        repeat (10) @(posedge CK_i);
        @(negedge CK_i);
        model_reset();
    endtask

    task automatic quiesce();
        for (int i = 0; i < 4; i++) tick_step(8'h00, 4, 0, 1'b0);
        tick_step(8'h00, 0, 0, 1'b1);
        got_q.delete();
    endtask

    task automatic test_reset();
        XARST_i = 1'b1;
        KEYS_i  = 8'h00;
        CLR_i   = 1'b0;
        POP_i   = 1'b0;
        repeat (2) @(negedge CK_i);
        do_reset();
        n_chk++;
        if ({EV_VALID_o, COUNT_o, KEYS_DEB_o, OVF_o, FULL_o} !== '0) begin
            n_err++;
            $display("FAIL reset_idle got v=%0b cnt=%0d deb=%h ovf=%0b full=%0b exp all 0",
                     EV_VALID_o, COUNT_o, KEYS_DEB_o, OVF_o, FULL_o);
        end
    endtask

    task automatic test_bounce();
        tick_step(8'h04, 0, 0, 1'b0);
        tick_step(8'h04, 0, 0, 1'b0);
        tick_step(8'h00, 0, 0, 1'b0);
        tick_step(8'h00, 0, 0, 1'b0);
        tick_step(8'h04, 0, 0, 1'b0);
        tick_step(8'h04, 0, 0, 1'b0);
        n_chk++;
        if (KEYS_DEB_o !== 8'h00 || COUNT_o !== '0) begin
            n_err++; $display("FAIL bounce_early got deb=%h cnt=%0d exp deb=00 cnt=0", KEYS_DEB_o, COUNT_o);
        end
        tick_step(8'h04, 0, 0, 1'b0);
        n_chk++;
        if (KEYS_DEB_o !== 8'h04 || COUNT_o !== CW'(1) || EV_KEY_o !== 3'd2 || EV_TYPE_o !== 2'b01) begin
            n_err++;
            $display("FAIL bounce_accept got deb=%h cnt=%0d key=%0d type=%0d exp deb=04 cnt=1 key=2 type=1",
                     KEYS_DEB_o, COUNT_o, EV_KEY_o, EV_TYPE_o);
        end
        n_chk++;
        if (cnt_trace[1] != 0 || cnt_trace[2] != 1) begin
            n_err++; $display("FAIL bounce_latency got c1=%0d c2=%0d exp c1=0 c2=1", cnt_trace[1], cnt_trace[2]);
        end
    endtask

    task automatic test_repeat();
        logic [4:0] exp [5];
        exp[0] = 5'b101_01; exp[1] = 5'b101_11; exp[2] = 5'b101_11;
        exp[3] = 5'b101_11; exp[4] = 5'b101_10;
        quiesce();
        for (int t = 0; t < 3 + 17; t++) tick_step(8'h20, 2, 0, 1'b0);
        for (int t = 0; t < 3 + 6; t++) tick_step(8'h00, 2, 0, 1'b0);
        n_chk++;
        if (got_q.size() != 5) begin
            n_err++; $display("FAIL repeat_count got %0d exp 5", got_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size()) begin
                n_chk++;
                if (got_q[i] !== exp[i]) begin
                    n_err++; $display("FAIL repeat_ev%0d got %b exp %b", i, got_q[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        quiesce();
        for (int t = 0; t < 3; t++) tick_step(8'h81, 0, 0, 1'b0);
        n_chk++;
        if (cnt_trace[1] != 0 || cnt_trace[2] != 1 || key_trace[2] != 0 || cnt_trace[3] != 2 || key_trace[3] != 0) begin
            n_err++;
            $display("FAIL simul_order got c1=%0d c2=%0d k2=%0d c3=%0d k3=%0d exp 0 1 0 2 0",
                     cnt_trace[1], cnt_trace[2], key_trace[2], cnt_trace[3], key_trace[3]);
        end
        n_chk++;
        if (COUNT_o !== CW'(2)) begin
            n_err++; $display("FAIL simul_count got %0d exp 2", COUNT_o);
        end
        tick_step(8'h81, 1, 0, 1'b0);
        n_chk++;
        if (EV_KEY_o !== 3'd7 || EV_TYPE_o !== 2'b01) begin
            n_err++; $display("FAIL simul_second got key=%0d type=%0d exp key=7 type=1", EV_KEY_o, EV_TYPE_o);
        end
    endtask

    task automatic test_overflow();
        quiesce();
        for (int t = 0; t < 3; t++) tick_step(8'h1F, 0, 0, 1'b0);
        n_chk++;
        if (FULL_o !== 1'b1 || COUNT_o !== CW'(4) || OVF_o !== 1'b1 || EV_KEY_o !== 3'd0 || EV_TYPE_o !== 2'b01) begin
            n_err++;
            $display("FAIL ovf_state got full=%0b cnt=%0d ovf=%0b key=%0d type=%0d exp 1 4 1 0 1",
                     FULL_o, COUNT_o, OVF_o, EV_KEY_o, EV_TYPE_o);
        end
        got_q.delete();
        tick_step(8'h1F, 4, 0, 1'b0);
        n_chk++;
        if (got_q.size() != 4) begin
            n_err++; $display("FAIL ovf_pops got %0d exp 4", got_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) begin
                n_chk++;
                if (got_q[i] !== {3'(i), 2'b01}) begin
                    n_err++; $display("FAIL ovf_order%0d got %b exp key=%0d type=1", i, got_q[i], i);
                end
            end
        end
        n_chk++;
        if (OVF_o !== 1'b1 || COUNT_o !== '0) begin
            n_err++; $display("FAIL ovf_sticky got ovf=%0b cnt=%0d exp ovf=1 cnt=0", OVF_o, COUNT_o);
        end
    endtask

    task automatic test_full_push_pop();
        quiesce();
        for (int t = 0; t < 3; t++) tick_step(8'h0F, 0, 0, 1'b0);
        tick_step(8'h1F, 0, 0, 1'b0);
        tick_step(8'h1F, 0, 0, 1'b0);
        tick_step(8'h1F, 0, 2, 1'b0);
        n_chk++;
        if (cnt_trace[1] != 4 || cnt_trace[2] != 4 || COUNT_o !== CW'(4) || OVF_o !== 1'b0 || FULL_o !== 1'b1) begin
            n_err++;
            $display("FAIL fullpp got c1=%0d c2=%0d cnt=%0d ovf=%0b full=%0b exp 4 4 4 0 1",
                     cnt_trace[1], cnt_trace[2], COUNT_o, OVF_o, FULL_o);
        end
        n_chk++;
        if (EV_KEY_o !== 3'd1) begin
            n_err++; $display("FAIL fullpp_head got key=%0d exp key=1", EV_KEY_o);
        end
    endtask

    task automatic test_clear();
        quiesce();
        for (int t = 0; t < 3 + 10; t++) tick_step(8'h08, 0, 0, 1'b0);
        n_chk++;
        if (COUNT_o !== CW'(2)) begin
            n_err++; $display("FAIL clr_pre got cnt=%0d exp 2", COUNT_o);
        end
        tick_step(8'h08, 0, 0, 1'b1);
        n_chk++;
        if (COUNT_o !== '0 || OVF_o !== 1'b0 || KEYS_DEB_o !== 8'h08) begin
            n_err++;
            $display("FAIL clr_post got cnt=%0d ovf=%0b deb=%h exp cnt=0 ovf=0 deb=08", COUNT_o, OVF_o, KEYS_DEB_o);
        end
        for (int i = 2; i <= 10; i++) begin
            tick_step(8'h08, 0, 0, 1'b0);
            if (i == 9) begin
                n_chk++;
                if (COUNT_o !== '0) begin
                    n_err++; $display("FAIL clr_norep got cnt=%0d exp 0", COUNT_o);
                end
            end
            if (i == 10) begin
                n_chk++;
                if (COUNT_o !== CW'(1) || EV_KEY_o !== 3'd3 || EV_TYPE_o !== 2'b11) begin
                    n_err++;
                    $display("FAIL clr_rep got cnt=%0d key=%0d type=%0d exp cnt=1 key=3 type=3",
                             COUNT_o, EV_KEY_o, EV_TYPE_o);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        quiesce();
        tick_step(8'h40, 0, 0, 1'b0);
        tick_step(8'h40, 0, 0, 1'b0);
        do_reset();
        tick_step(8'h40, 0, 0, 1'b0);
        tick_step(8'h40, 0, 0, 1'b0);
        n_chk++;
        if (KEYS_DEB_o !== 8'h00) begin
            n_err++; $display("FAIL rst_restart got deb=%h exp 00", KEYS_DEB_o);
        end
        tick_step(8'h40, 0, 0, 1'b0);
        n_chk++;
        if (KEYS_DEB_o !== 8'h40) begin
            n_err++; $display("FAIL rst_accept got deb=%h exp 40", KEYS_DEB_o);
        end
    endtask

    task automatic test_random();
        logic [7:0] cur;
        int         npop;
        int         pc;
        bit         clr;
        quiesce();
        cur = 8'h00;
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 9) < 3) cur = cur ^ 8'($urandom);
            npop = $urandom_range(0, 3);
            pc   = $urandom_range(0, 5);
            if (pc > 2) pc = 0;
            clr  = ($urandom_range(0, 19) == 0);
            tick_step(cur, npop, pc, clr);
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        model_reset();
        test_reset();
        test_bounce();
        test_repeat();
        test_simultaneous();
        test_overflow();
        test_full_push_pop();
        test_clear();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
